m68k_bus_sequencer: RTL and testbench

- Drives one 68000 bus cycle per host request from the fast system clock.
- Oversamples the asynchronous 68000 clock and walks bus states S0..S7, inserting wait states until DTACK or BERR.
- Sits directly upstream of the data-capture latch stage. It generates that stage's SET and RESET strobes and the bus control pins.

---
 rtl/m68k_bus_sequencer.sv | 308 ++++++++++++++++++++++++++++++
 tb/tb_m68k_bus_sequencer.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/m68k_bus_sequencer.sv
// m68k_bus_sequencer
// Runs one 68000 bus cycle (S0..S7) for each host request. The 68000 clock
// is oversampled on i_clk, and the FSM advances only on the synchronized
// rise/fall events of that clock. It inserts wait states in S4 until DTACK,
// BERR or the wait limit is reached. It also drives the SET/RESET strobes of
// the downstream data-capture latch.
//
// state | meaning
// IDLE  | no cycle; waiting for a RISE with i_req high
// S0    | cycle latched, capture latch cleared
// S1    | address phase
// S2    | AS asserted; read strobes asserted; write drives RW/data
// S3    | write data strobes asserted
// S4    | wait states; each FALL samples DTACK/BERR
// S5    | DTACK seen, data settling
// S6    | data valid on bus
// S7    | strobes released; read data captured
`timescale 1ns/100ps

module m68k_bus_sequencer #(
    parameter int WAIT_W   = 8,
    parameter int WAIT_MAX = 255
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic       i_m68k_clk,
    input  logic       i_dtack_n,
    input  logic       i_berr_n,
    input  logic       i_req,
    input  logic       i_req_rw,
    input  logic       i_req_uds,
    input  logic       i_req_lds,
    output logic       o_as_n,
    output logic       o_uds_n,
    output logic       o_lds_n,
    output logic       o_rw,
    output logic       o_data_oe,
    output logic       o_latch_set,
    output logic       o_latch_reset,
    output logic       o_busy,
    output logic       o_ack,
    output logic [1:0] o_err
);

    localparam logic [3:0] ST_IDLE = 4'd0;
    localparam logic [3:0] ST_S0   = 4'd1;
    localparam logic [3:0] ST_S1   = 4'd2;
    localparam logic [3:0] ST_S2   = 4'd3;
    localparam logic [3:0] ST_S3   = 4'd4;
    localparam logic [3:0] ST_S4   = 4'd5;
    localparam logic [3:0] ST_S5   = 4'd6;
    localparam logic [3:0] ST_S6   = 4'd7;
    localparam logic [3:0] ST_S7   = 4'd8;

    localparam logic [1:0] ERR_OK   = 2'b00;
    localparam logic [1:0] ERR_BERR = 2'b01;
    localparam logic [1:0] ERR_TMO  = 2'b10;

    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_MAX);
    localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);

    // synchronizer stages
    logic              r_mclk_s1;
    logic              r_mclk_s2;
    logic              r_mclk_s3;
    logic              r_dtack_s1;
    logic              r_dtack_s2;
    logic              r_berr_s1;
    logic              r_berr_s2;

    // FSM and cycle context
    logic [3:0]        r_state;
    logic [WAIT_W-1:0] r_wait_cnt;
    logic              r_cyc_rw;
    logic              r_cyc_uds;
    logic              r_cyc_lds;

    // registered outputs
    logic              r_as_n;
    logic              r_uds_n;
    logic              r_lds_n;
    logic              r_rw;
    logic              r_data_oe;
    logic              r_latch_set;
    logic              r_latch_reset;
    logic              r_busy;
    logic              r_ack;
    logic [1:0]        r_err;

    // next-state values
    logic              w_rise;
    logic              w_fall;
    logic [WAIT_W-1:0] w_cnt_inc;
    logic              w_release;
    logic [3:0]        w_state_nxt;
    logic [WAIT_W-1:0] w_wait_cnt_nxt;
    logic              w_cyc_rw_nxt;
    logic              w_cyc_uds_nxt;
    logic              w_cyc_lds_nxt;
    logic              w_as_n_nxt;
    logic              w_uds_n_nxt;
    logic              w_lds_n_nxt;
    logic              w_rw_nxt;
    logic              w_data_oe_nxt;
    logic              w_latch_set_nxt;
    logic              w_latch_reset_nxt;
    logic              w_busy_nxt;
    logic              w_ack_nxt;
    logic [1:0]        w_err_nxt;

    // Two-flop synchronizers; the third M68K clock flop provides the edge history.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_mclk_s1  <= 1'b1;
            r_mclk_s2  <= 1'b1;
            r_mclk_s3  <= 1'b1;
            r_dtack_s1 <= 1'b1;
            r_dtack_s2 <= 1'b1;
            r_berr_s1  <= 1'b1;
            r_berr_s2  <= 1'b1;
        end else begin
            r_mclk_s1  <= i_m68k_clk;
            r_mclk_s2  <= r_mclk_s1;
            r_mclk_s3  <= r_mclk_s2;
            r_dtack_s1 <= i_dtack_n;
            r_dtack_s2 <= r_dtack_s1;
            r_berr_s1  <= i_berr_n;
            r_berr_s2  <= r_berr_s1;
        end
    end

    // RISE and FALL come from a single pair of flops, so they cannot coincide.
    assign w_rise    = r_mclk_s2 & ~r_mclk_s3;
    assign w_fall    = ~r_mclk_s2 & r_mclk_s3;
    assign w_cnt_inc = r_wait_cnt + WAIT_ONE;

    // Bus-state walk: compute next state and next value of every registered output.
    always_comb begin
        w_state_nxt       = r_state;
        w_wait_cnt_nxt    = r_wait_cnt;
        w_cyc_rw_nxt      = r_cyc_rw;
        w_cyc_uds_nxt     = r_cyc_uds;
        w_cyc_lds_nxt     = r_cyc_lds;
        w_as_n_nxt        = r_as_n;
        w_uds_n_nxt       = r_uds_n;
        w_lds_n_nxt       = r_lds_n;
        w_rw_nxt          = r_rw;
        w_data_oe_nxt     = r_data_oe;
        w_busy_nxt        = r_busy;
        w_err_nxt         = r_err;
        w_latch_set_nxt   = 1'b0;
        w_latch_reset_nxt = 1'b0;
        w_ack_nxt         = 1'b0;
        w_release         = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_rise && i_req) begin
                    w_state_nxt       = ST_S0;
                    w_cyc_rw_nxt      = i_req_rw;
                    w_cyc_uds_nxt     = i_req_uds;
                    w_cyc_lds_nxt     = i_req_lds;
                    w_err_nxt         = ERR_OK;
                    w_busy_nxt        = 1'b1;
                    w_latch_reset_nxt = 1'b1;
                end
            end
            ST_S0: begin
                if (w_fall) begin
                    w_state_nxt = ST_S1;
                end
            end
            ST_S1: begin
                if (w_rise) begin
                    w_state_nxt = ST_S2;
                    w_as_n_nxt  = 1'b0;
                    if (r_cyc_rw) begin
                        w_uds_n_nxt = ~r_cyc_uds;
                        w_lds_n_nxt = ~r_cyc_lds;
                    end else begin
                        w_rw_nxt      = 1'b0;
                        w_data_oe_nxt = 1'b1;
                    end
                end
            end
            ST_S2: begin
                if (w_fall) begin
                    w_state_nxt = ST_S3;
                    // write strobes wait one half-clock so data is set up first
                    if (!r_cyc_rw) begin
                        w_uds_n_nxt = ~r_cyc_uds;
                        w_lds_n_nxt = ~r_cyc_lds;
                    end
                end
            end
            ST_S3: begin
                if (w_rise) begin
                    w_state_nxt = ST_S4;
                end
            end
            ST_S4: begin
                if (w_fall) begin
                    if (!r_berr_s2) begin
                        w_state_nxt = ST_S7;
                        w_err_nxt   = ERR_BERR;
                        w_release   = 1'b1;
                    end else if (!r_dtack_s2) begin
                        w_state_nxt = ST_S5;
                    end else begin
                        w_wait_cnt_nxt = w_cnt_inc;
                        if (w_cnt_inc == WAIT_LAST) begin
                            w_state_nxt = ST_S7;
                            w_err_nxt   = ERR_TMO;
                            w_release   = 1'b1;
                        end
                    end
                end
            end
            ST_S5: begin
                if (w_rise) begin
                    w_state_nxt = ST_S6;
                end
            end
            ST_S6: begin
                if (w_fall) begin
                    w_state_nxt = ST_S7;
                    w_release   = 1'b1;
                    if (r_cyc_rw && (r_err == ERR_OK)) begin
                        w_latch_set_nxt = 1'b1;
                    end
                end
            end
            ST_S7: begin
                if (w_rise) begin
                    w_state_nxt    = ST_IDLE;
                    w_rw_nxt       = 1'b1;
                    w_busy_nxt     = 1'b0;
                    w_wait_cnt_nxt = '0;
                    w_ack_nxt      = 1'b1;
                end
            end
            default: begin
                // unreachable encodings fall back to a quiet bus
                w_state_nxt    = ST_IDLE;
                w_rw_nxt       = 1'b1;
                w_busy_nxt     = 1'b0;
                w_wait_cnt_nxt = '0;
                w_release      = 1'b1;
            end
        endcase

        if (w_release) begin
            w_as_n_nxt    = 1'b1;
            w_uds_n_nxt   = 1'b1;
            w_lds_n_nxt   = 1'b1;
            w_data_oe_nxt = 1'b0;
        end
    end

    // State, cycle context and outputs register together; reset aborts any cycle.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state       <= ST_IDLE;
            r_wait_cnt    <= '0;
            r_cyc_rw      <= 1'b1;
            r_cyc_uds     <= 1'b0;
            r_cyc_lds     <= 1'b0;
            r_as_n        <= 1'b1;
            r_uds_n       <= 1'b1;
            r_lds_n       <= 1'b1;
            r_rw          <= 1'b1;
            r_data_oe     <= 1'b0;
            r_latch_set   <= 1'b0;
            r_latch_reset <= 1'b0;
            r_busy        <= 1'b0;
            r_ack         <= 1'b0;
            r_err         <= ERR_OK;
        end else begin
            r_state       <= w_state_nxt;
            r_wait_cnt    <= w_wait_cnt_nxt;
            r_cyc_rw      <= w_cyc_rw_nxt;
            r_cyc_uds     <= w_cyc_uds_nxt;
            r_cyc_lds     <= w_cyc_lds_nxt;
            r_as_n        <= w_as_n_nxt;
            r_uds_n       <= w_uds_n_nxt;
            r_lds_n       <= w_lds_n_nxt;
            r_rw          <= w_rw_nxt;
            r_data_oe     <= w_data_oe_nxt;
            r_latch_set   <= w_latch_set_nxt;
            r_latch_reset <= w_latch_reset_nxt;
            r_busy        <= w_busy_nxt;
            r_ack         <= w_ack_nxt;
            r_err         <= w_err_nxt;
        end
    end

    assign o_as_n        = r_as_n;
    assign o_uds_n       = r_uds_n;
    assign o_lds_n       = r_lds_n;
    assign o_rw          = r_rw;
    assign o_data_oe     = r_data_oe;
    assign o_latch_set   = r_latch_set;
    assign o_latch_reset = r_latch_reset;
    assign o_busy        = r_busy;
    assign o_ack         = r_ack;
    assign o_err         = r_err;

endmodule

// File: tb/tb_m68k_bus_sequencer.sv
// Testbench for m68k_bus_sequencer. Each table entry gives the request,
// when DTACK/BERR are driven (counted in bus half-clocks from the start of
// the cycle) and the expected cycle shape. Expected values are queued when
// a request is issued and checked when its ACK arrives.
`timescale 1ns/100ps

module tb_m68k_bus_sequencer;

    localparam int WAIT_W   = 8;
    localparam int WAIT_MAX = 4;

    logic       clk     = 1'b0;
    logic       rst_n   = 1'b1;
    logic       mclk    = 1'b0;
    logic       dtack_n = 1'b1;
    logic       berr_n  = 1'b1;
    logic       req     = 1'b0;
    logic       req_rw  = 1'b1;
    logic       req_uds = 1'b0;
    logic       req_lds = 1'b0;
    logic       as_n, uds_n, lds_n, rw, data_oe;
    logic       latch_set, latch_reset, busy, ack;
    logic [1:0] err;

    m68k_bus_sequencer #(.WAIT_W(WAIT_W), .WAIT_MAX(WAIT_MAX)) dut (
        .i_clk(clk), .i_reset_n(rst_n), .i_m68k_clk(mclk),
        .i_dtack_n(dtack_n), .i_berr_n(berr_n),
        .i_req(req), .i_req_rw(req_rw), .i_req_uds(req_uds), .i_req_lds(req_lds),
        .o_as_n(as_n), .o_uds_n(uds_n), .o_lds_n(lds_n), .o_rw(rw),
        .o_data_oe(data_oe), .o_latch_set(latch_set), .o_latch_reset(latch_reset),
        .o_busy(busy), .o_ack(ack), .o_err(err)
    );

    // 100 MHz system clock; bus clock edges fall on half-ns points, never on a CLK edge
    always #5 clk = ~clk;
    initial begin
        #0.5;
        forever #37 mclk = ~mclk;
    end

    // -1 in an index field means "never happens in this cycle"
    typedef struct {
        bit vrw; bit vuds; bit vlds;
        int dtack_at; int berr_at; bit drop_req;
        int xerr; int xhalf; int xls_n; int xls_i;
        int xas_i; int xuds_i; int xlds_i; int xrw0_i; int xoe_i; int xrel_i;
    } vec_t;

    vec_t vecs[9];
    vec_t exp_q[$];

    int n_checks = 0;
    int n_errors = 0;

    // monitor state
    logic prev_mclk = 1'b0;
    bit   active = 0, ack_seen = 0, both_seen = 0, busy_drop = 0;
    int   edges = 0, gap = 0, last_gap = 0, ack_cnt = 0, stray = 0;
    int   ls_n, ls_i, as_i, uds_i, lds_i, rw0_i, oe_i, rel_i;

    function automatic vec_t mk(bit r, bit u, bit l, int da, int ba, bit dr, int xe, int h,
                                int lsn, int lsi, int asi, int ui, int li, int r0, int oe, int rel);
        vec_t v;
        v.vrw = r; v.vuds = u; v.vlds = l; v.dtack_at = da; v.berr_at = ba; v.drop_req = dr;
        v.xerr = xe; v.xhalf = h; v.xls_n = lsn; v.xls_i = lsi; v.xas_i = asi;
        v.xuds_i = ui; v.xlds_i = li; v.xrw0_i = r0; v.xoe_i = oe; v.xrel_i = rel;
        return v;
    endfunction

    task automatic check(input string name, input int act, input int expv);
        n_checks++;
        if (act !== expv) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    // One CLK step; samples the DUT on the falling edge and scores completed cycles.
    task automatic tick();
        vec_t e;
        @(negedge clk);
        if (mclk !== prev_mclk) begin
            edges++;
            gap++;
        end
        prev_mclk = mclk;
        if (latch_set && !active && !latch_reset) stray++;
        if (latch_reset) begin
            active = 1; edges = 0; last_gap = gap;
            ls_n = 0; ls_i = -1; as_i = -1; uds_i = -1; lds_i = -1;
            rw0_i = -1; oe_i = -1; rel_i = -1; busy_drop = 0; both_seen = 0;
        end else if (active) begin
            if (!as_n && as_i < 0) as_i = edges;
            if (as_n && as_i >= 0 && rel_i < 0) rel_i = edges;
            if (!uds_n && uds_i < 0) uds_i = edges;
            if (!lds_n && lds_i < 0) lds_i = edges;
            if (!rw && rw0_i < 0) rw0_i = edges;
            if (data_oe && oe_i < 0) oe_i = edges;
            if (latch_set) begin
                ls_n++;
                if (ls_i < 0) ls_i = edges;
            end
            if (!ack && !busy) busy_drop = 1;
        end
        if (latch_set && latch_reset) both_seen = 1;
        if (ack) begin
            ack_cnt++;
            ack_seen = 1;
            gap = 0;
            if (exp_q.size() == 0 || !active) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_ack: got ack with %0d pending, active=%0d", exp_q.size(), active);
            end else begin
                e = exp_q.pop_front();
                check("err", int'(err), e.xerr);
                check("half_clocks", edges, e.xhalf);
                check("latch_set_count", ls_n, e.xls_n);
                check("latch_set_at", ls_i, e.xls_i);
                check("as_low_at", as_i, e.xas_i);
                check("uds_low_at", uds_i, e.xuds_i);
                check("lds_low_at", lds_i, e.xlds_i);
                check("rw_low_at", rw0_i, e.xrw0_i);
                check("data_oe_at", oe_i, e.xoe_i);
                check("strobe_release_at", rel_i, e.xrel_i);
                check("bus_idle_at_ack", int'({as_n, uds_n, lds_n, data_oe, rw}), 29);
                check("busy_at_ack", int'(busy), 0);
                check("busy_held", int'(busy_drop), 0);
                check("set_reset_overlap", int'(both_seen), 0);
            end
            active = 0;
        end
    endtask

    task automatic run_txn(input vec_t v);
        int budget;
        req_rw = v.vrw; req_uds = v.vuds; req_lds = v.vlds;
        dtack_n = 1'b1; berr_n = 1'b1; req = 1'b1;
        exp_q.push_back(v);
        ack_seen = 0;
        budget = 0;
        while (!ack_seen && budget < 600) begin
            tick();
            budget++;
            if (active) begin
                if (v.drop_req) req = 1'b0;
                if (v.dtack_at >= 0 && edges >= v.dtack_at) dtack_n = 1'b0;
                if (v.berr_at >= 0 && edges >= v.berr_at) berr_n = 1'b0;
            end
        end
        if (!ack_seen) begin
            n_checks++;
            n_errors++;
            $display("FAIL ack_timeout: no ack after %0d cycles", budget);
            exp_q.delete();
        end
        req = 1'b0; dtack_n = 1'b1; berr_n = 1'b1;
        repeat (3) tick();
    endtask

    initial begin
        int budget;
        int acks_before;

        //               rw u l  dtk  berr drp err half lsn lsi as uds lds rw0 oe rel
        vecs[0] = mk(1, 1, 1,  2, -1, 0, 0,  8, 1,  7, 2,  2,  2, -1, -1,  7); // read, zero wait
        vecs[1] = mk(0, 0, 1,  2, -1, 0, 0,  8, 0, -1, 2, -1,  3,  2,  2,  7); // write, lower byte
        vecs[2] = mk(1, 1, 1, 10, -1, 0, 0, 14, 1, 13, 2,  2,  2, -1, -1, 13); // read, 3 waits
        vecs[3] = mk(1, 1, 1,  4,  4, 0, 1,  6, 0, -1, 2,  2,  2, -1, -1,  5); // BERR beats DTACK
        vecs[4] = mk(1, 1, 0, -1, -1, 0, 2, 12, 0, -1, 2,  2, -1, -1, -1, 11); // read timeout
        vecs[5] = mk(1, 0, 0,  2, -1, 1, 0,  8, 1,  7, 2, -1, -1, -1, -1,  7); // no lanes, REQ drops
        vecs[6] = mk(0, 1, 1,  6, -1, 0, 0, 10, 0, -1, 2,  3,  3,  2,  2,  9); // write word, 1 wait
        vecs[7] = mk(1, 1, 0, -1,  8, 0, 1, 10, 0, -1, 2,  2, -1, -1, -1,  9); // BERR after 2 waits
        vecs[8] = mk(0, 1, 0, -1, -1, 0, 2, 12, 0, -1, 2,  3, -1,  2,  2, 11); // write timeout

        // reset values, checked while reset is held
        #2 rst_n = 1'b0;
        #1;
        check("rst_strobes", int'({as_n, uds_n, lds_n, rw}), 15);
        check("rst_data_oe", int'(data_oe), 0);
        check("rst_latch", int'({latch_set, latch_reset}), 0);
        check("rst_busy_ack", int'({busy, ack}), 0);
        check("rst_err", int'(err), 0);
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (20) tick();

        for (int i = 0; i < 9; i++) begin
            run_txn(vecs[i]);
        end

        // back-to-back: REQ never drops and DTACK is low from the start
        exp_q.push_back(vecs[0]);
        exp_q.push_back(vecs[0]);
        req_rw = 1'b1; req_uds = 1'b1; req_lds = 1'b1;
        dtack_n = 1'b0; berr_n = 1'b1; req = 1'b1;
        acks_before = ack_cnt;
        budget = 0;
        while ((ack_cnt - acks_before) < 2 && budget < 800) begin
            tick();
            budget++;
        end
        check("b2b_acks", ack_cnt - acks_before, 2);
        check("b2b_idle_half_clocks", last_gap, 2);
        req = 1'b0; dtack_n = 1'b1;
        exp_q.delete();
        repeat (20) tick();

        // reset in the middle of S4 wait states
        req_rw = 1'b1; req_uds = 1'b1; req_lds = 1'b1; req = 1'b1;
        budget = 0;
        while (!(active && edges >= 5) && budget < 300) begin
            tick();
            budget++;
        end
        check("reached_s4", int'(active && edges >= 5), 1);
        check("busy_before_reset", int'(busy), 1);
        check("as_before_reset", int'(as_n), 0);
        rst_n = 1'b0;
        #1;
        check("abort_strobes", int'({as_n, uds_n, lds_n, rw}), 15);
        check("abort_oe_busy", int'({data_oe, busy, ack}), 0);
        check("abort_latch_err", int'({latch_set, latch_reset, err}), 0);
        req = 1'b0;
        active = 0;
        stray = 0;
        acks_before = ack_cnt;
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (60) tick();
        check("no_ack_after_abort", ack_cnt - acks_before, 0);
        check("no_latch_set_after_abort", stray, 0);

        // the next request must start cleanly with LATCH_RESET at S0
        run_txn(vecs[0]);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
